// File: rtl/pulse_step_counter_if.sv
// rtl/pulse_step_counter_if.sv - control inputs and status outputs of pulse_step_counter
interface pulse_step_counter_if #(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4,
   parameter int DIV_WIDTH  = 4
);
   logic                  enable;
   logic [DIV_WIDTH-1:0]  divide;
   logic                  up;
   logic [STEP_WIDTH-1:0] step;
   logic                  saturate;
   logic                  load;
   logic [WIDTH-1:0]      load_value;
   logic [WIDTH-1:0]      value;
   logic                  tick;
   logic                  limit;

   modport master (
      output enable, divide, up, step, saturate, load, load_value,
      input  value, tick, limit
   );

   modport slave (
      input  enable, divide, up, step, saturate, load, load_value,
      output value, tick, limit
   );
endinterface

// File: rtl/pulse_step_counter.sv
// rtl/pulse_step_counter.sv - up/down counter with clock-enable prescaler, runtime step, wrap or saturate
module pulse_step_counter #(
   parameter int               WIDTH       = 8,
   parameter int               STEP_WIDTH  = 4,
   parameter int               DIV_WIDTH   = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
   input logic                 clock,
   input logic                 reset_,
   pulse_step_counter_if.slave bus
);
   logic [DIV_WIDTH-1:0] pcnt;
   logic [WIDTH-1:0]     count;
   logic                 tick_q;
   logic                 limit_q;
   logic [WIDTH:0]       step_ext;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic                 fire;
   logic                 wrapped;
   logic [WIDTH-1:0]     next_count;

   assign step_ext = (WIDTH+1)'(bus.step);
   assign sum      = {1'b0, count} + step_ext;
   assign diff     = {1'b0, count} - step_ext;

   // >= rather than == so that lowering divide mid-period fires on the next enabled edge
   assign fire = (pcnt >= bus.divide);

   always_comb begin
      wrapped    = 1'b0;
      next_count = count;
      if (bus.up) begin
         wrapped    = sum[WIDTH];
         next_count = sum[WIDTH-1:0];
         if (wrapped && bus.saturate)
            next_count = {WIDTH{1'b1}};
      end else begin
         wrapped    = diff[WIDTH];
         next_count = diff[WIDTH-1:0];
         if (wrapped && bus.saturate)
            next_count = {WIDTH{1'b0}};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         count   <= RESET_VALUE;
         pcnt    <= '0;
         tick_q  <= 1'b0;
         limit_q <= 1'b0;
      end else if (bus.load) begin
         count   <= bus.load_value;
         pcnt    <= '0;
         tick_q  <= 1'b0;
         limit_q <= 1'b0;
      end else if (bus.enable) begin
         tick_q <= fire;
         if (fire) begin
            pcnt    <= '0;
            count   <= next_count;
            limit_q <= wrapped;
         end else begin
            pcnt    <= pcnt + DIV_WIDTH'(1);
            limit_q <= 1'b0;
         end
      end else begin
         tick_q  <= 1'b0;
         limit_q <= 1'b0;
      end
   end

   assign bus.value = count;
   assign bus.tick  = tick_q;
   assign bus.limit = limit_q;
endmodule

// File: tb/tb_pulse_step_counter.sv
// tb/tb_pulse_step_counter.sv - randomized and directed bench for pulse_step_counter
module tb_pulse_step_counter;
   localparam int W  = 8;
   localparam int SW = 4;
   localparam int DW = 4;
   localparam int MAXV = (1 << W) - 1;

   logic clock = 1'b0;
   logic reset_ = 1'b0;

   pulse_step_counter_if #(.WIDTH(W), .STEP_WIDTH(SW), .DIV_WIDTH(DW)) bus ();

   pulse_step_counter #(
      .WIDTH(W), .STEP_WIDTH(SW), .DIV_WIDTH(DW), .RESET_VALUE(8'hFF)
   ) dut (
      .clock (clock),
      .reset_(reset_),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // reference state: phase counts enabled edges since the last tick/reset/load
   int m_value = 0;
   int m_phase = 0;
   bit m_tick = 0;
   bit m_limit = 0;

   task automatic model_edge();
      int r;
      if (!reset_) begin
         m_value = MAXV; m_phase = 0; m_tick = 0; m_limit = 0;
      end else if (bus.load) begin
         m_value = int'(bus.load_value); m_phase = 0; m_tick = 0; m_limit = 0;
      end else if (!bus.enable) begin
         m_tick = 0; m_limit = 0;
      end else if (m_phase >= int'(bus.divide)) begin
         m_phase = 0;
         m_tick  = 1;
         r = bus.up ? m_value + int'(bus.step) : m_value - int'(bus.step);
         if (r > MAXV || r < 0) begin
            m_limit = 1;
            m_value = bus.saturate ? (bus.up ? MAXV : 0) : (r & MAXV);
         end else begin
            m_limit = 0;
            m_value = r;
         end
      end else begin
         m_phase = m_phase + 1;
         m_tick = 0; m_limit = 0;
      end
   endtask

   task automatic step_clk();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [W-1:0] v, input logic en);
      bus.load = 1'b1; bus.load_value = v; bus.enable = en;
      step_clk();
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      bus.enable = 1'b1; bus.divide = '0; bus.up = 1'b1; bus.step = 4'd1;
      bus.saturate = 1'b0; bus.load = 1'b1; bus.load_value = 8'h33;
      reset_ = 1'b0;
      step_clk();
      step_clk();
      checks++;
      if (bus.value !== 8'hFF) begin
         failures++; $display("FAIL reset_value got=%h exp=ff", bus.value);
      end
      checks++;
      if (bus.tick !== 1'b0 || bus.limit !== 1'b0) begin
         failures++; $display("FAIL reset_pulses got tick=%b limit=%b exp=0/0", bus.tick, bus.limit);
      end
      bus.load = 1'b0; bus.enable = 1'b0;
      reset_ = 1'b1;
      step_clk();
   endtask

   task automatic test_divider();
      logic [W-1:0] ev;
      logic et;
      do_load(8'h10, 1'b0);
      checks++;
      if (bus.value !== 8'h10 || bus.tick !== 1'b0) begin
         failures++; $display("FAIL div_load got=%h tick=%b exp=10/0", bus.value, bus.tick);
      end
      bus.divide = 4'd3; bus.up = 1'b1; bus.step = 4'd1; bus.saturate = 1'b0; bus.enable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step_clk();
         ev = (k >= 8) ? 8'h12 : (k >= 4) ? 8'h11 : 8'h10;
         et = (k % 4 == 0);
         checks++;
         if (bus.value !== ev || bus.tick !== et || bus.limit !== 1'b0) begin
            failures++;
            $display("FAIL div_edge%0d got=%h tick=%b limit=%b exp=%h/%b/0",
                     k, bus.value, bus.tick, bus.limit, ev, et);
         end
      end
   endtask

   task automatic test_wrap_saturate();
      bus.divide = '0; bus.step = 4'd3; bus.up = 1'b1; bus.saturate = 1'b0;
      do_load(8'hFE, 1'b1);
      step_clk();
      checks++;
      if (bus.value !== 8'h01 || bus.limit !== 1'b1 || bus.tick !== 1'b1) begin
         failures++; $display("FAIL wrap_up got=%h limit=%b tick=%b exp=01/1/1", bus.value, bus.limit, bus.tick);
      end
      bus.saturate = 1'b1;
      do_load(8'hFE, 1'b1);
      step_clk();
      checks++;
      if (bus.value !== 8'hFF || bus.limit !== 1'b1) begin
         failures++; $display("FAIL sat_up got=%h limit=%b exp=ff/1", bus.value, bus.limit);
      end
      step_clk();
      checks++;
      if (bus.value !== 8'hFF || bus.limit !== 1'b1 || bus.tick !== 1'b1) begin
         failures++; $display("FAIL sat_rail got=%h limit=%b tick=%b exp=ff/1/1", bus.value, bus.limit, bus.tick);
      end
   endtask

   task automatic test_underflow();
      bus.divide = '0; bus.step = 4'd5; bus.up = 1'b0; bus.saturate = 1'b0;
      do_load(8'h02, 1'b1);
      step_clk();
      checks++;
      if (bus.value !== 8'hFD || bus.limit !== 1'b1) begin
         failures++; $display("FAIL wrap_down got=%h limit=%b exp=fd/1", bus.value, bus.limit);
      end
      bus.saturate = 1'b1;
      do_load(8'h02, 1'b1);
      step_clk();
      checks++;
      if (bus.value !== 8'h00 || bus.limit !== 1'b1) begin
         failures++; $display("FAIL sat_down got=%h limit=%b exp=00/1", bus.value, bus.limit);
      end
      bus.step = 4'd0;
      step_clk();
      checks++;
      if (bus.value !== 8'h00 || bus.limit !== 1'b0 || bus.tick !== 1'b1) begin
         failures++; $display("FAIL step_zero got=%h limit=%b tick=%b exp=00/0/1", bus.value, bus.limit, bus.tick);
      end
   endtask

   task automatic test_priority();
      bus.divide = '0; bus.step = 4'd1; bus.up = 1'b1; bus.saturate = 1'b0;
      do_load(8'h20, 1'b1);
      bus.load = 1'b1; bus.load_value = 8'h40;
      step_clk();
      checks++;
      if (bus.value !== 8'h40 || bus.tick !== 1'b0) begin
         failures++; $display("FAIL load_over_tick got=%h tick=%b exp=40/0", bus.value, bus.tick);
      end
      reset_ = 1'b0;
      step_clk();
      checks++;
      if (bus.value !== 8'hFF || bus.tick !== 1'b0) begin
         failures++; $display("FAIL reset_over_load got=%h tick=%b exp=ff/0", bus.value, bus.tick);
      end
      reset_ = 1'b1; bus.load = 1'b0;
   endtask

   task automatic test_enable_gating();
      bus.divide = 4'd5; bus.step = 4'd1; bus.up = 1'b1; bus.saturate = 1'b0;
      do_load(8'h00, 1'b0);
      bus.enable = 1'b1;
      for (int k = 0; k < 3; k++) step_clk();
      bus.enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step_clk();
         checks++;
         if (bus.value !== 8'h00 || bus.tick !== 1'b0) begin
            failures++; $display("FAIL gate_hold%0d got=%h tick=%b exp=00/0", k, bus.value, bus.tick);
         end
      end
      bus.enable = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step_clk();
         checks++;
         if (bus.tick !== (k == 3) || bus.value !== ((k == 3) ? 8'h01 : 8'h00)) begin
            failures++; $display("FAIL gate_resume%0d got=%h tick=%b", k, bus.value, bus.tick);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         reset_         = ($urandom_range(0, 99) != 0);
         bus.load       = ($urandom_range(0, 39) == 0);
         bus.load_value = W'($urandom);
         bus.enable     = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 15) == 0) bus.divide = DW'($urandom_range(0, 4));
         bus.up         = 1'($urandom);
         bus.step       = SW'($urandom);
         bus.saturate   = 1'($urandom);
         step_clk();
         checks++;
         if (bus.value !== W'(m_value) || bus.tick !== m_tick || bus.limit !== m_limit) begin
            failures++;
            $display("FAIL random%0d got=%h/%b/%b exp=%h/%b/%b",
                     n, bus.value, bus.tick, bus.limit, W'(m_value), m_tick, m_limit);
         end
      end
      reset_ = 1'b1;
   endtask

   initial begin
      bus.enable = 1'b0; bus.divide = '0; bus.up = 1'b1; bus.step = '0;
      bus.saturate = 1'b0; bus.load = 1'b0; bus.load_value = '0;
      test_reset();
      test_divider();
      test_wrap_saturate();
      test_underflow();
      test_priority();
      test_enable_gating();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pulse_step_counter.md
# pulse_step_counter

Parametrised up/down counter with an internal clock-enable prescaler, runtime step size, wrap or saturate overflow handling, synchronous load, and per-update status pulses. It replaces the earlier fixed 8-bit counter that relied on a derived half-rate clock. All logic runs in the single `clock` domain, with the rate set by a programmable divider. It sits between UI inputs (mouse button/position) and display/value consumers.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `STEP_WIDTH`, default 4: width of the step input.
- `DIV_WIDTH`, default 4: width of the prescaler divide input.
- `RESET_VALUE`, default {WIDTH{1'b1}}: value loaded on reset.
- `clock`  in  1: sole clock. All state updates on its rising edge.
- `reset_`  in  1: synchronous, active-low reset.
- `enable`  in  1: prescaler and counting run while high; all state holds while low.
- `divide`  in  DIV_WIDTH: one counting tick every `divide`+1 enabled clocks.
- `up`  in  1: 1 = count up, 0 = count down. Sampled on the tick cycle.
- `step`  in  STEP_WIDTH: amount added or subtracted per tick, zero-extended.
- `saturate`  in  1: 1 = clamp at 0 / 2^WIDTH-1; 0 = modular wrap.
- `load`  in  1: synchronous load of `load_value`.
- `load_value`  in  WIDTH: value to load.
- `value`  out  WIDTH: current count, registered.
- `tick`  out  1: one-cycle pulse, high in the cycle after `value` was updated by a counting tick.
- `limit`  out  1: one-cycle pulse, high with `tick` when that tick overflowed or underflowed (wrap or clamp).

## Operation
- Reset (`reset_`=0 at an edge):
  - `value`=RESET_VALUE.
  - Prescaler count `pcnt`=0.
  - `tick`=0, `limit`=0.
  - Reset overrides `load` and `enable`.
- Priority at each edge: reset > load > tick > hold.
- Load (`load`=1):
  - `value`<=`load_value`, `pcnt`<=0, `tick`<=0, `limit`<=0.
  - Independent of `enable`; no counting occurs that cycle.
- Prescaler (`enable`=1, no load):
  - If `pcnt` >= `divide`: tick fires this edge and `pcnt`<=0.
  - Otherwise `pcnt`<=`pcnt`+1.
  - Using >= means lowering `divide` mid-count fires on the next enabled edge rather than waiting for wrap.
  - `divide`=0 gives a tick on every enabled edge.
- `enable`=0: `pcnt`, `value` hold; `tick`, `limit`<=0.
- Tick arithmetic: computed at WIDTH+1 bits.
  - Up: sum = value + step. Overflow when the carry (bit WIDTH) is set.
  - Down: diff = value − step. Underflow when the borrow is set (step > value).
  - No overflow/underflow: `value`<=result, `limit`<=0.
  - Overflow/underflow with `saturate`=0: `value`<=result[WIDTH-1:0], `limit`<=1.
  - Overflow/underflow with `saturate`=1: `value`<=2^WIDTH-1 (up) or 0 (down), `limit`<=1.
  - At a rail already, a further tick with step>0 in saturate mode holds `value` and pulses `limit` again.
  - `step`=0: `value` unchanged, `tick`<=1, `limit`<=0.
- `tick`<=1 on every tick edge; 0 otherwise.

## Timing
- `value`, `tick`, `limit` are registered and update on the same edge. No combinational input-to-output paths.
- Tick rate: after reset release or load with `enable` held high, first counting update at the (`divide`+1)th rising edge. Updates then repeat every `divide`+1 edges.
- Dropping `enable` freezes `pcnt`. Re-asserting resumes the count where it left off, with no lost or extra tick.
- `up`, `step`, `saturate` are sampled only on tick edges. Changes between ticks have no effect.
- Reset or load in the middle of a prescaler period discards that period.

## Test plan
- Reset with WIDTH=8: `reset_`=0 for 2 cycles -> `value`=8'hFF, `tick`=0, `limit`=0.
- Divider period: `divide`=3, `up`=1, `step`=1, `enable`=1 from value 8'h10 -> `value` 8'h11 on edge 4, 8'h12 on edge 8; `tick` high exactly once per 4 cycles.
- Wrap vs saturate: value 8'hFE, `step`=3, `up`=1, `divide`=0.
  - `saturate`=0 -> 8'h01 with `limit`=1.
  - `saturate`=1 -> 8'hFF with `limit`=1; next tick 8'hFF, `limit`=1 again.
- Down underflow: value 8'h02, `step`=5, `up`=0.
  - `saturate`=0 -> 8'hFD, `limit`=1.
  - `saturate`=1 -> 8'h00, `limit`=1.
- Priority: `load`=1 with `load_value`=8'h40 on a tick edge -> `value`=8'h40, `tick`=0. Same cycle with `reset_`=0 -> `value`=8'hFF.
- Enable gating: `divide`=5, drop `enable` after 3 enabled edges for 10 cycles, then re-raise -> next tick 3 enabled edges later; `value` constant while disabled.
